// File: rtl/instruction_fetch_queue.sv
// Per-strand instruction FIFO between the fetch pipeline and strand select.
//
// Each strand owns a DEPTH-entry queue of 66-bit entries
// {long_latency, branch_predicted, pc, instruction}. The head of every strand
// is presented combinationally on the concatenated if_* buses. Strand select
// pops with ss_instruction_req, and rollback flushes a strand. Fetch is
// throttled per strand through a registered, slack-based ready signal.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   ifc_write_en           one instruction delivered this cycle
//   ifc_write_strand       destination strand of the delivered instruction
//   ifc_instruction/pc     instruction word and its PC (+4)
//   ifc_branch_predicted   predicted-taken flag
//   ifc_long_latency       predecoded multi-cycle flag
//   ss_instruction_req     per-strand pop request
//   rb_rollback_strand     per-strand flush request
//   if_*                   per-strand head entry (strand s at [s*32 +: 32])
//   fq_fetch_ready         per-strand "may fetch" (registered)
//   fq_overflow            one-cycle pulse when a write to a full queue was dropped

module instruction_fetch_queue #(
  parameter int unsigned NUM_STRANDS = 4,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned FETCH_SLACK = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             ifc_write_en,
  input  logic [$clog2(NUM_STRANDS)-1:0]   ifc_write_strand,
  input  logic [31:0]                      ifc_instruction,
  input  logic [31:0]                      ifc_pc,
  input  logic                             ifc_branch_predicted,
  input  logic                             ifc_long_latency,
  input  logic [NUM_STRANDS-1:0]           ss_instruction_req,
  input  logic [NUM_STRANDS-1:0]           rb_rollback_strand,
  output logic [NUM_STRANDS-1:0]           if_instruction_valid,
  output logic [NUM_STRANDS*32-1:0]        if_instruction,
  output logic [NUM_STRANDS*32-1:0]        if_pc,
  output logic [NUM_STRANDS-1:0]           if_branch_predicted,
  output logic [NUM_STRANDS-1:0]           if_long_latency,
  output logic [NUM_STRANDS-1:0]           fq_fetch_ready,
  output logic                             fq_overflow
);

  localparam int unsigned STRAND_W = $clog2(NUM_STRANDS);
  localparam int unsigned PTR_W    = $clog2(DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned ENTRY_W  = 66;

  // Empty strands present this encoding so they never look like a hazard.
  localparam logic [31:0]      NOP_INSTR  = 32'h0000_0013;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [ENTRY_W-1:0]     storage_q [NUM_STRANDS][DEPTH];
  logic [PTR_W-1:0]       rd_ptr_q  [NUM_STRANDS];
  logic [PTR_W-1:0]       rd_ptr_d  [NUM_STRANDS];
  logic [PTR_W-1:0]       wr_ptr_q  [NUM_STRANDS];
  logic [PTR_W-1:0]       wr_ptr_d  [NUM_STRANDS];
  logic [CNT_W-1:0]       count_q   [NUM_STRANDS];
  logic [CNT_W-1:0]       count_d   [NUM_STRANDS];
  logic [NUM_STRANDS-1:0] fetch_ready_q, fetch_ready_d;
  logic                   overflow_q;

  logic [NUM_STRANDS-1:0] strand_sel;
  logic [NUM_STRANDS-1:0] is_full;
  logic [NUM_STRANDS-1:0] push;
  logic [NUM_STRANDS-1:0] pop;
  logic [NUM_STRANDS-1:0] drop;
  logic [ENTRY_W-1:0]     wr_entry;

  assign wr_entry = {ifc_long_latency, ifc_branch_predicted, ifc_pc, ifc_instruction};

  // Next-state for every strand queue.
  always_comb begin
    strand_sel    = '0;
    is_full       = '0;
    push          = '0;
    pop           = '0;
    drop          = '0;
    fetch_ready_d = '0;
    for (int s = 0; s < NUM_STRANDS; s++) begin
      rd_ptr_d[s] = rd_ptr_q[s];
      wr_ptr_d[s] = wr_ptr_q[s];
      count_d[s]  = count_q[s];

      strand_sel[s] = ifc_write_en && (ifc_write_strand == STRAND_W'(s));
      is_full[s]    = (count_q[s] == FULL_COUNT);
      pop[s]        = ss_instruction_req[s] && (count_q[s] != '0);
      // A same-cycle pop frees a slot, so a full queue can still accept.
      push[s]       = strand_sel[s] && !rb_rollback_strand[s] && (!is_full[s] || pop[s]);
      // Writes swallowed by a rollback are intentionally not reported.
      drop[s]       = strand_sel[s] && !rb_rollback_strand[s] && is_full[s] && !pop[s];

      if (rb_rollback_strand[s]) begin
        rd_ptr_d[s] = '0;
        wr_ptr_d[s] = '0;
        count_d[s]  = '0;
      end else begin
        if (pop[s]) begin
          rd_ptr_d[s] = rd_ptr_q[s] + PTR_W'(1);
        end
        if (push[s]) begin
          wr_ptr_d[s] = wr_ptr_q[s] + PTR_W'(1);
        end
        count_d[s] = count_q[s] + CNT_W'(push[s]) - CNT_W'(pop[s]);
      end

      // Leave room for the writes still in flight once ready drops.
      fetch_ready_d[s] = (32'(count_d[s]) + FETCH_SLACK) <= DEPTH;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NUM_STRANDS; s++) begin
        rd_ptr_q[s] <= '0;
        wr_ptr_q[s] <= '0;
        count_q[s]  <= '0;
      end
      fetch_ready_q <= '1;
      overflow_q    <= 1'b0;
    end else begin
      for (int s = 0; s < NUM_STRANDS; s++) begin
        rd_ptr_q[s] <= rd_ptr_d[s];
        wr_ptr_q[s] <= wr_ptr_d[s];
        count_q[s]  <= count_d[s];
      end
      fetch_ready_q <= fetch_ready_d;
      overflow_q    <= |drop;
    end
  end

  // Entry storage is never cleared; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    for (int s = 0; s < NUM_STRANDS; s++) begin
      if (push[s]) begin
        storage_q[s][wr_ptr_q[s]] <= wr_entry;
      end
    end
  end

  // Head presentation.
  always_comb begin
    if_instruction_valid = '0;
    if_instruction       = '0;
    if_pc                = '0;
    if_branch_predicted  = '0;
    if_long_latency      = '0;
    for (int s = 0; s < NUM_STRANDS; s++) begin
      if (count_q[s] != '0) begin
        if_instruction_valid[s]  = 1'b1;
        if_instruction[s*32+:32] = storage_q[s][rd_ptr_q[s]][31:0];
        if_pc[s*32+:32]          = storage_q[s][rd_ptr_q[s]][63:32];
        if_branch_predicted[s]   = storage_q[s][rd_ptr_q[s]][64];
        if_long_latency[s]       = storage_q[s][rd_ptr_q[s]][65];
      end else begin
        if_instruction[s*32+:32] = NOP_INSTR;
      end
    end
  end

  assign fq_fetch_ready = fetch_ready_q;
  assign fq_overflow    = overflow_q;

endmodule
